avoid_ctrl: RTL and testbench

AVOID_CTRL -- requirements
Module: avoid_ctrl

---
 rtl/avoid_ctrl.sv | 164 ++++++++++++++++
 tb/tb_avoid_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avoid_ctrl.sv
// Obstacle-avoidance motor controller: debounces three object flags and runs a
// Moore FSM that cruises, reverses, and turns away from qualified obstacles.
module avoid_ctrl #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned REV_CYCLES  = 8,
    parameter int unsigned TURN_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       left_object,
    input  logic       right_object,
    input  logic       front_object,
    output logic       drive_fwd,
    output logic       drive_rev,
    output logic       turn_left,
    output logic       turn_right,
    output logic       busy,
    output logic [7:0] maneuver_cnt
);

    localparam logic [7:0] DEB_MAX   = 8'(DEB_CYCLES);
    localparam logic [7:0] REV_LOAD  = 8'(REV_CYCLES - 1);
    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_STOP,
        ST_CRUISE,
        ST_REVERSE,
        ST_TURN_L,
        ST_TURN_R
    } state_t;

    logic [2:0] w_obj;
    logic [2:0] w_q;
    logic       w_lq;
    logic       w_rq;
    logic       w_fq;

    assign w_obj = {front_object, right_object, left_object};

    // One saturating debounce counter per flag; the qualified flag is the
    // registered "next count reached the threshold" so it drops on the first low sample.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            logic [7:0] r_cnt;
            logic [7:0] w_cnt_next;
            logic       r_q;

            always_comb begin
                w_cnt_next = 8'd0;
                if (w_obj[gi]) begin
                    if (r_cnt >= DEB_MAX) begin
                        w_cnt_next = DEB_MAX;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= 8'd0;
                    r_q   <= 1'b0;
                end else begin
                    r_cnt <= w_cnt_next;
                    r_q   <= (w_cnt_next == DEB_MAX);
                end
            end

            assign w_q[gi] = r_q;
        end
    endgenerate

    assign w_lq = w_q[0];
    assign w_rq = w_q[1];
    assign w_fq = w_q[2];

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_timer;
    logic [7:0] w_timer_next;
    logic [7:0] r_mcnt;
    logic [7:0] w_mcnt_next;
    logic       w_turn_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STOP;
            r_timer <= 8'd0;
            r_mcnt  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_mcnt  <= w_mcnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_turn_start = 1'b0;
        if (!enable) begin
            w_state_next = ST_STOP;
            w_timer_next = 8'd0;
        end else begin
            case (r_state)
                ST_STOP: begin
                    w_state_next = ST_CRUISE;
                end
                ST_CRUISE: begin
                    if (w_fq) begin
                        w_state_next = ST_REVERSE;
                        w_timer_next = REV_LOAD;
                    end else if (w_lq) begin
                        w_state_next = ST_TURN_R;
                        w_timer_next = TURN_LOAD;
                        w_turn_start = 1'b1;
                    end else if (w_rq) begin
                        w_state_next = ST_TURN_L;
                        w_timer_next = TURN_LOAD;
                        w_turn_start = 1'b1;
                    end
                end
                ST_REVERSE: begin
                    // Side flags only matter on the last reverse cycle.
                    if (r_timer == 8'd0) begin
                        w_state_next = (w_rq && !w_lq) ? ST_TURN_L : ST_TURN_R;
                        w_timer_next = TURN_LOAD;
                        w_turn_start = 1'b1;
                    end else begin
                        w_timer_next = r_timer - 8'd1;
                    end
                end
                ST_TURN_L, ST_TURN_R: begin
                    if (r_timer == 8'd0) begin
                        w_state_next = ST_CRUISE;
                    end else begin
                        w_timer_next = r_timer - 8'd1;
                    end
                end
                default: begin
                    w_state_next = ST_STOP;
                    w_timer_next = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_mcnt_next = r_mcnt;
        if (w_turn_start && (r_mcnt != 8'd255)) begin
            w_mcnt_next = r_mcnt + 8'd1;
        end
    end

    assign drive_fwd    = (r_state == ST_CRUISE);
    assign drive_rev    = (r_state == ST_REVERSE);
    assign turn_left    = (r_state == ST_TURN_L);
    assign turn_right   = (r_state == ST_TURN_R);
    assign busy         = (r_state == ST_REVERSE) || (r_state == ST_TURN_L) || (r_state == ST_TURN_R);
    assign maneuver_cnt = r_mcnt;

endmodule

// File: tb/tb_avoid_ctrl.sv
// Self-checking bench for avoid_ctrl: directed scenarios plus random flag traffic,
// every cycle compared against a cycle-count model of the controller's rules.
module tb_avoid_ctrl;

    localparam int DEB  = 4;
    localparam int REV  = 8;
    localparam int TURN = 16;

    localparam int M_STOP   = 0;
    localparam int M_CRUISE = 1;
    localparam int M_REV    = 2;
    localparam int M_TL     = 3;
    localparam int M_TR     = 4;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic       lo     = 1'b0;
    logic       ro     = 1'b0;
    logic       fo     = 1'b0;
    logic       drive_fwd;
    logic       drive_rev;
    logic       turn_left;
    logic       turn_right;
    logic       busy;
    logic [7:0] maneuver_cnt;

    int checks   = 0;
    int failures = 0;

    int m_dcnt[3];
    bit m_q[3];
    int m_mode;
    int m_left;
    int m_turns;

    avoid_ctrl #(
        .DEB_CYCLES (DEB),
        .REV_CYCLES (REV),
        .TURN_CYCLES(TURN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .left_object (lo),
        .right_object(ro),
        .front_object(fo),
        .drive_fwd   (drive_fwd),
        .drive_rev   (drive_rev),
        .turn_left   (turn_left),
        .turn_right  (turn_right),
        .busy        (busy),
        .maneuver_cnt(maneuver_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_dcnt[i] = 0;
            m_q[i]    = 1'b0;
        end
        m_mode  = M_STOP;
        m_left  = 0;
        m_turns = 0;
    endfunction

    function automatic void start_turn(input int dir);
        m_mode = dir;
        m_left = TURN;
        if (m_turns < 255) m_turns = m_turns + 1;
    endfunction

    // One rising edge: the controller reacts to the flags qualified before this edge.
    function automatic void model_edge(input bit en, input bit [2:0] obj);
        bit lq = m_q[0];
        bit rq = m_q[1];
        bit fq = m_q[2];
        if (!en) begin
            m_mode = M_STOP;
            m_left = 0;
        end else begin
            case (m_mode)
                M_STOP:   m_mode = M_CRUISE;
                M_CRUISE: begin
                    if (fq) begin
                        m_mode = M_REV;
                        m_left = REV;
                    end else if (lq) begin
                        start_turn(M_TR);
                    end else if (rq) begin
                        start_turn(M_TL);
                    end
                end
                M_REV: begin
                    if (m_left > 1) m_left = m_left - 1;
                    else start_turn((rq && !lq) ? M_TL : M_TR);
                end
                default: begin
                    if (m_left > 1) m_left = m_left - 1;
                    else m_mode = M_CRUISE;
                end
            endcase
        end
        for (int i = 0; i < 3; i++) begin
            if (obj[i]) m_dcnt[i] = (m_dcnt[i] < DEB) ? m_dcnt[i] + 1 : DEB;
            else m_dcnt[i] = 0;
            m_q[i] = (m_dcnt[i] == DEB);
        end
    endfunction

    function automatic logic [4:0] exp_out();
        case (m_mode)
            M_CRUISE: return 5'b10000;
            M_REV:    return 5'b01001;
            M_TL:     return 5'b00101;
            M_TR:     return 5'b00011;
            default:  return 5'b00000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_outs"}, {27'd0, drive_fwd, drive_rev, turn_left, turn_right, busy},
              {27'd0, exp_out()});
        check({tag, "_cnt"}, {24'd0, maneuver_cnt}, m_turns);
    endtask

    task automatic step(input bit en, input bit l, input bit r, input bit f, input string tag);
        enable = en;
        lo     = l;
        ro     = r;
        fo     = f;
        @(posedge clk);
        if (reset) model_edge(en, {f, r, l});
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int nrev;
        int ntr;
        int ntl;
        int nbusy;
        int tr_starts;
        bit prev_tr;
        bit rl;
        bit rr;
        bit rf;
        bit ren;

        model_reset();
        enable = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);

        // Reset held, then released with enable high.
        check_all("rst_hold");
        step(1, 0, 0, 0, "rst_hold2");
        reset = 1'b1;
        step(1, 0, 0, 0, "release");
        check("release_fwd", {31'd0, drive_fwd}, 32'd1);
        check("release_cnt", {24'd0, maneuver_cnt}, 32'd0);

        // Left flag too short to qualify.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, "short_left");
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, "short_left_off");
        check("short_left_fwd", {31'd0, drive_fwd}, 32'd1);

        // Front object: full reverse + right turn.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, "front_hold");
        nrev = 0; ntr = 0; nbusy = 0;
        for (int i = 0; i < 28; i++) begin
            step(1, 0, 0, 0, "front_man");
            nrev  += int'(drive_rev);
            ntr   += int'(turn_right);
            nbusy += int'(busy);
        end
        check("front_rev_len", nrev, REV);
        check("front_tr_len", ntr, TURN);
        check("front_busy_len", nbusy, REV + TURN);
        check("front_cnt", {24'd0, maneuver_cnt}, 32'd1);
        check("front_back_fwd", {31'd0, drive_fwd}, 32'd1);

        // Left and front qualify together; right held through reverse -> left turn.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, "lf_hold");
        step(1, 0, 1, 0, "lf_enter");
        check("lf_rev_first", {31'd0, drive_rev}, 32'd1);
        ntl = 0; ntr = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1, 0, "lf_right_hold");
            ntl += int'(turn_left);
            ntr += int'(turn_right);
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, "lf_turn");
            ntl += int'(turn_left);
            ntr += int'(turn_right);
        end
        check("lf_tl_len", ntl, TURN);
        check("lf_tr_none", ntr, 0);
        check("lf_cnt", {24'd0, maneuver_cnt}, 32'd2);

        // Enable dropped in the fifth cycle of a right turn.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, "abort_hold");
        step(1, 0, 0, 0, "abort_enter");
        check("abort_tr", {31'd0, turn_right}, 32'd1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, "abort_turn");
        step(0, 0, 0, 0, "abort_stop");
        check("abort_outs", {27'd0, drive_fwd, drive_rev, turn_left, turn_right, busy}, 32'd0);
        check("abort_cnt_kept", {24'd0, maneuver_cnt}, 32'd3);
        step(1, 0, 0, 0, "abort_resume");

        // Asynchronous reset mid-turn.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, "arst_hold");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, "arst_turn");
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("arst_async");
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        step(1, 0, 0, 0, "arst_hold_low");
        reset = 1'b1;
        step(1, 0, 0, 0, "arst_release");

        // Random flag traffic with occasional enable drops.
        rl = 0; rr = 0; rf = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) rl = ~rl;
            if ($urandom_range(5) == 0) rr = ~rr;
            if ($urandom_range(7) == 0) rf = ~rf;
            ren = ($urandom_range(49) != 0);
            step(ren, rl, rr, rf, "rand");
        end

        // Counter saturation: back-to-back right turns from a fresh reset.
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        step(1, 0, 0, 0, "sat_rst");
        reset = 1'b1;
        tr_starts = 0;
        prev_tr   = 1'b0;
        for (int i = 0; i < 4500; i++) begin
            step(1, 1, 0, 0, "sat");
            if (turn_right && !prev_tr) tr_starts++;
            prev_tr = turn_right;
        end
        check("sat_turns_257", {31'd0, (tr_starts >= 257)}, 32'd1);
        check("sat_cnt", {24'd0, maneuver_cnt}, 32'd255);
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0, "sat_hold");
        check("sat_cnt_hold", {24'd0, maneuver_cnt}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
